// File: rtl/led_bank_arbiter_pkg.sv
// Shared types and constants for the LED bank arbiter.
// Holds the FSM state type, the default owner tenure and the counter-width helper.
package led_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int HOLD_CYCLES_DEFAULT = 2**24;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_bank_arbiter_if.sv
// Request/pattern/duty bundle from the status sources and grant/LED drive back.
// master = source side, slave = arbiter side.
interface led_bank_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int LED_W   = 8,
    parameter int PWM_W   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LED_W-1:0] pattern;
    logic [NUM_REQ*PWM_W-1:0] duty;
    logic [NUM_REQ-1:0]       grant;
    logic                     owner_valid;
    logic [LED_W-1:0]         leds;

    modport master (output req, pattern, duty, input grant, owner_valid, leds);
    modport slave  (input req, pattern, duty, output grant, owner_valid, leds);
endinterface

// File: rtl/led_bank_arbiter_rr_pick.sv
// Combinational round-robin pick: first set candidate at or above ptr_i, wrapping.
// Zero latency; no flow control.
module led_rr_pick
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = cnt_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] cand_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               any_o
);
    int idx;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // explicit wrap keeps non-power-of-2 NUM_REQ correct
            idx = int'(ptr_i) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any_o && cand_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                idx_o      = PTR_W'(idx);
            end
        end
    end
endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the LED bank with minimum tenure and per-source PWM brightness.
// grant one edge after request, leds one edge after grant; locked low idles the bank.
module led_bank_arbiter
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int LED_W       = 8,
    parameter int PWM_W       = 8,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                locked,
    led_bank_arbiter_if.slave   bus
);
    localparam int PTR_W  = cnt_width(NUM_REQ);
    localparam int HOLD_W = cnt_width(HOLD_CYCLES + 1);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               owner_valid_q, owner_valid_d;
    logic [LED_W-1:0]   leds_q, leds_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] cand, pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any, owner_req, take;
    logic [LED_W-1:0]   own_pat;
    logic [PWM_W-1:0]   own_duty;
    logic               pwm_on;

    // While owning, the owner is never a candidate; if it dropped, req & ~grant == req.
    assign cand      = (state_q == OWN) ? (bus.req & ~grant_q) : bus.req;
    assign owner_req = |(bus.req & grant_q);

    led_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .cand_i (cand),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_comb begin
        own_pat  = '0;
        own_duty = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                own_pat  = bus.pattern[i*LED_W +: LED_W];
                own_duty = bus.duty[i*PWM_W +: PWM_W];
            end
        end
        if (own_duty == '0)
            pwm_on = 1'b0;
        else if (own_duty == {PWM_W{1'b1}})
            pwm_on = 1'b1;
        else
            pwm_on = (pwm_cnt_q < own_duty);
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        hold_cnt_d = hold_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        take       = 1'b0;
        if (!locked) begin
            state_d    = IDLE;
            grant_d    = '0;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: take = pick_any;
                OWN: begin
                    if (!owner_req) begin
                        if (pick_any) begin
                            take = 1'b1;
                        end else begin
                            state_d    = IDLE;
                            grant_d    = '0;
                            hold_cnt_d = '0;
                        end
                    end else if (hold_cnt_q == '0) begin
                        take = pick_any;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (take) begin
            state_d    = OWN;
            grant_d    = pick_gnt;
            hold_cnt_d = HOLD_W'(HOLD_CYCLES - 1);
            rr_ptr_d   = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
        end
        owner_valid_d = |grant_d;
        leds_d        = (locked && owner_valid_q) ? (own_pat & {LED_W{pwm_on}}) : '0;
        pwm_cnt_d     = pwm_cnt_q + PWM_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            owner_valid_q <= 1'b0;
            leds_q        <= '0;
            hold_cnt_q    <= '0;
            pwm_cnt_q     <= '0;
            rr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_valid_q <= owner_valid_d;
            leds_q        <= leds_d;
            hold_cnt_q    <= hold_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.owner_valid = owner_valid_q;
    assign bus.leds        = leds_q;
endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter with a 4-cycle hold so tenure effects are visible.
module tb_led_bank_arbiter;
    localparam int NUM_REQ = 4;
    localparam int LED_W   = 8;
    localparam int PWM_W   = 8;
    localparam int HOLD    = 4;

    logic clk = 1'b0;
    logic reset;
    logic locked;
    int   errors = 0;
    int   checks = 0;

    led_bank_arbiter_if #(.NUM_REQ(NUM_REQ), .LED_W(LED_W), .PWM_W(PWM_W)) bus ();

    led_bank_arbiter #(
        .NUM_REQ(NUM_REQ), .LED_W(LED_W), .PWM_W(PWM_W), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .locked (locked),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        bus.req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        locked = 1'b1;
        bus.req = '0;
        bus.pattern = {8'h00, 8'h00, 8'h00, 8'h11};
        bus.duty = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tick();
        tick();
        checks++;
        if ({bus.grant, bus.owner_valid, bus.leds} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state: got grant=%b ov=%b leds=%h expected all zero",
                     bus.grant, bus.owner_valid, bus.leds);
        end
        reset = 1'b0;
        bus.req = 4'hF;
        tick();
        tick();
        checks++;
        if (bus.grant !== 4'b0001 || bus.leds !== 8'h11) begin
            errors++;
            $display("FAIL pre_reset_owner: got grant=%b leds=%h expected 0001/11",
                     bus.grant, bus.leds);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.grant, bus.owner_valid, bus.leds} !== 13'd0) begin
            errors++;
            $display("FAIL async_reset: got grant=%b ov=%b leds=%h expected all zero",
                     bus.grant, bus.owner_valid, bus.leds);
        end
        #1 reset = 1'b0;
        tick();
        checks++;
        if (bus.grant !== 4'b0001 || bus.owner_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: got grant=%b ov=%b expected 0001/1",
                     bus.grant, bus.owner_valid);
        end
        go_idle();
    endtask

    task automatic test_single();
        bus.pattern = {8'h00, 8'hA5, 8'h00, 8'h11};
        bus.req = 4'b0100;
        tick();
        checks++;
        if (bus.grant !== 4'b0100 || bus.leds !== 8'h00) begin
            errors++;
            $display("FAIL single_grant: got grant=%b leds=%h expected 0100/00",
                     bus.grant, bus.leds);
        end
        tick();
        checks++;
        if (bus.leds !== 8'hA5) begin
            errors++;
            $display("FAIL single_leds: got %h expected a5", bus.leds);
        end
        repeat (6) tick();
        checks++;
        if (bus.grant !== 4'b0100 || bus.leds !== 8'hA5) begin
            errors++;
            $display("FAIL single_steady: got grant=%b leds=%h expected 0100/a5",
                     bus.grant, bus.leds);
        end
        go_idle();
    endtask

    task automatic test_alternate();
        logic [3:0] exp_g;
        bus.req = 4'b0011;
        for (int k = 0; k < 12; k++) begin
            tick();
            exp_g = (((k / HOLD) % 2) == 0) ? 4'b0001 : 4'b0010;
            checks++;
            if (bus.grant !== exp_g) begin
                errors++;
                $display("FAIL alternate cycle %0d: got grant=%b expected %b",
                         k, bus.grant, exp_g);
            end
        end
        go_idle();
    endtask

    task automatic test_pwm();
        int on_cnt;
        int bad;
        bus.pattern = {8'h00, 8'h00, 8'h00, 8'hFF};
        bus.duty = {8'hFF, 8'hFF, 8'hFF, 8'd64};
        bus.req = 4'b0001;
        tick();
        tick();
        on_cnt = 0;
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            tick();
            if (bus.leds === 8'hFF) on_cnt++;
            else if (bus.leds !== 8'h00) bad++;
        end
        checks++;
        if (on_cnt !== 64 || bad !== 0) begin
            errors++;
            $display("FAIL pwm_duty64: got on=%0d odd=%0d expected on=64 odd=0", on_cnt, bad);
        end
        bus.duty = {8'hFF, 8'hFF, 8'hFF, 8'd0};
        tick();
        on_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            tick();
            if (bus.leds !== 8'h00) on_cnt++;
        end
        checks++;
        if (on_cnt !== 0) begin
            errors++;
            $display("FAIL pwm_duty0: got %0d lit cycles expected 0", on_cnt);
        end
        bus.duty = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tick();
        on_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            tick();
            if (bus.leds === 8'hFF) on_cnt++;
        end
        checks++;
        if (on_cnt !== 256) begin
            errors++;
            $display("FAIL pwm_duty255: got %0d lit cycles expected 256", on_cnt);
        end
        go_idle();
    endtask

    task automatic test_drop();
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b1001;
        tick();
        checks++;
        if (bus.grant !== 4'b0001) begin
            errors++;
            $display("FAIL drop_hold: got grant=%b expected 0001", bus.grant);
        end
        bus.req = 4'b1000;
        tick();
        checks++;
        if (bus.grant !== 4'b1000 || bus.owner_valid !== 1'b1) begin
            errors++;
            $display("FAIL drop_handover: got grant=%b ov=%b expected 1000/1",
                     bus.grant, bus.owner_valid);
        end
        go_idle();
    endtask

    task automatic test_lock();
        bus.pattern = {8'h00, 8'h00, 8'h3C, 8'hFF};
        bus.req = 4'b0010;
        tick();
        tick();
        checks++;
        if (bus.grant !== 4'b0010 || bus.leds !== 8'h3C) begin
            errors++;
            $display("FAIL lock_owner: got grant=%b leds=%h expected 0010/3c",
                     bus.grant, bus.leds);
        end
        locked = 1'b0;
        tick();
        checks++;
        if ({bus.grant, bus.owner_valid, bus.leds} !== 13'd0) begin
            errors++;
            $display("FAIL lock_loss: got grant=%b ov=%b leds=%h expected all zero",
                     bus.grant, bus.owner_valid, bus.leds);
        end
        bus.req = 4'b0011;
        repeat (9) tick();
        checks++;
        if (bus.grant !== 4'b0000 || bus.leds !== 8'h00) begin
            errors++;
            $display("FAIL lock_hold_idle: got grant=%b leds=%h expected 0000/00",
                     bus.grant, bus.leds);
        end
        locked = 1'b1;
        tick();
        checks++;
        if (bus.grant !== 4'b0001) begin
            errors++;
            $display("FAIL relock_grant: got grant=%b expected 0001", bus.grant);
        end
        tick();
        checks++;
        if (bus.leds !== 8'hFF) begin
            errors++;
            $display("FAIL relock_leds: got %h expected ff", bus.leds);
        end
        go_idle();
    endtask

    initial begin
        reset = 1'b1;
        locked = 1'b1;
        bus.req = '0;
        bus.pattern = '0;
        bus.duty = '0;
        test_reset();
        test_single();
        test_alternate();
        test_pwm();
        test_drop();
        test_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
